// File: rtl/fp64_pkg.sv
// Shared binary64 field layout, constants and divider state encoding.
package fp64_pkg;

    localparam int EXP_W     = 11;
    localparam int FRAC_W    = 52;
    localparam int BIAS      = 1023;
    localparam int DIV_ITERS = 56;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp64_t;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

endpackage

// File: rtl/fp64_classify.sv
// Combinational operand decode; exponent field 0 is treated as zero (subnormals flushed).
module fp64_classify
    import fp64_pkg::*;
(
    input  fp64_t op,
    output logic  is_zero,
    output logic  is_inf,
    output logic  is_nan
);

    logic exp_max;

    assign exp_max = &op.exp;
    assign is_zero = (op.exp == '0);
    assign is_inf  = exp_max && (op.frac == '0);
    assign is_nan  = exp_max && (op.frac != '0);

endmodule

// File: rtl/fp64_seq_divider.sv
// Iterative radix-2 restoring binary64 divider, fixed 57-cycle latency, valid/ready on both sides.
// Optional FPDIV_EXCEPT_FLAGS_EN adds except_flags = {invalid, div_by_zero, overflow, underflow, inexact}.
module fp64_seq_divider
    import fp64_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] final_quotient
`ifdef FPDIV_EXCEPT_FLAGS_EN
    ,
    output logic [4:0]  except_flags
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and the result holds until taken.

    fp64_t a, b;
    logic  a_zero, a_inf, a_nan;
    logic  b_zero, b_inf, b_nan;

    assign a = A;
    assign b = B;

    fp64_classify u_class_a (.op(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    fp64_classify u_class_b (.op(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic        accept, last_iter;

    logic [53:0]        rem;
    logic [52:0]        mb_r;
    logic [55:0]        quo;
    logic signed [12:0] exp_r;
    logic               sign_r;
    logic               special_r;
    logic [63:0]        spec_r;

    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt == 6'(DIV_ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = DIV;
            DIV:     if (last_iter) state_next = ROUND;
            ROUND:                  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Special operands resolved at accept, first match wins.
    logic        spec_nan, spec_inf, spec_zero, res_sign;
    logic [63:0] spec_val;

    always_comb begin
        res_sign  = a.sign ^ b.sign;
        spec_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        spec_inf  = a_inf || b_zero;
        spec_zero = a_zero || b_inf;
        if (spec_nan)      spec_val = QNAN;
        else if (spec_inf) spec_val = {res_sign, 11'h7FF, 52'h0};
        else               spec_val = {res_sign, 63'h0};
    end

    // One restoring step: subtract the divisor when it fits, then shift the remainder.
    logic        ge;
    logic [53:0] rem_keep, rem_next;

    always_comb begin
        ge       = (rem >= {1'b0, mb_r});
        rem_keep = ge ? (rem - {1'b0, mb_r}) : rem;
        rem_next = rem_keep << 1;
    end

    // Normalize, round to nearest even, and range-check the exponent.
    logic               norm, g, s, rnd_up;
    logic [52:0]        mant;
    logic [53:0]        mant_r;
    logic [51:0]        frac_fin;
    logic signed [12:0] e_fin;
    logic               ovf, unf;
    logic [63:0]        norm_res;

    always_comb begin
        norm     = quo[55];
        mant     = norm ? quo[55:3] : quo[54:2];
        g        = norm ? quo[2] : quo[1];
        s        = norm ? (quo[1] | quo[0] | (rem != '0)) : (quo[0] | (rem != '0));
        rnd_up   = g & (s | mant[0]);
        mant_r   = {1'b0, mant} + {53'b0, rnd_up};
        frac_fin = mant_r[53] ? mant_r[52:1] : mant_r[51:0];
        e_fin    = exp_r - {12'b0, ~norm} + {12'b0, mant_r[53]};
        ovf      = (e_fin >= 13'sd2047);
        unf      = (e_fin <= 13'sd0);
        if (ovf)      norm_res = {sign_r, 11'h7FF, 52'h0};
        else if (unf) norm_res = {sign_r, 63'h0};
        else          norm_res = {sign_r, e_fin[10:0], frac_fin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem            <= '0;
            mb_r           <= '0;
            quo            <= '0;
            cnt            <= '0;
            exp_r          <= '0;
            sign_r         <= 1'b0;
            special_r      <= 1'b0;
            spec_r         <= '0;
            final_quotient <= '0;
        end else if (accept) begin
            rem       <= {2'b01, a.frac};
            mb_r      <= {1'b1, b.frac};
            quo       <= '0;
            cnt       <= '0;
            exp_r     <= {2'b00, a.exp} - {2'b00, b.exp} + 13'(BIAS);
            sign_r    <= res_sign;
            special_r <= spec_nan || spec_inf || spec_zero;
            spec_r    <= spec_val;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= {quo[54:0], ge};
            cnt <= cnt + 6'd1;
        end else if (state == ROUND) begin
            final_quotient <= special_r ? spec_r : norm_res;
        end
    end

`ifdef FPDIV_EXCEPT_FLAGS_EN
    // Signalling NaN = NaN with the quiet bit clear; inf/0 is an exact infinity, not div-by-zero.
    logic [4:0] spec_flags_r;
    logic       invalid, dbz;

    always_comb begin
        invalid = (a_nan && !a.frac[FRAC_W-1]) || (b_nan && !b.frac[FRAC_W-1]) ||
                  (a_zero && b_zero) || (a_inf && b_inf);
        dbz     = b_zero && !a_zero && !a_nan && !a_inf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_flags_r <= '0;
            except_flags <= '0;
        end else if (accept) begin
            spec_flags_r <= {invalid, dbz, 3'b000};
        end else if (state == ROUND) begin
            except_flags <= special_r ? spec_flags_r
                                      : {2'b00, ovf, unf, ovf | unf | g | s};
        end
    end
`endif

endmodule

// File: tb/tb_fp64_seq_divider.sv
// Directed-vector bench for fp64_seq_divider: driver pushes expectations, negedge monitor checks them.
module tb_fp64_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        in_ready, out_valid;
    logic [63:0] final_quotient;
`ifdef FPDIV_EXCEPT_FLAGS_EN
    logic [4:0]  except_flags;
`endif

    fp64_seq_divider dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .final_quotient(final_quotient)
`ifdef FPDIV_EXCEPT_FLAGS_EN
        , .except_flags(except_flags)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [63:0] exp_q[$];
    logic [4:0]  flg_q[$];
    string       nm_q[$];
    int          acc_q[$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: first cycle of out_valid checks value and latency, later cycles check hold.
    logic        seen = 1'b0;
    logic [63:0] held = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", final_quotient, 64'hx);
                end else begin
                    string nm;
                    int    acc;
                    logic [4:0] f;
                    nm  = nm_q.pop_front();
                    acc = acc_q.pop_front();
                    f   = flg_q.pop_front();
                    check({nm, "_value"}, final_quotient, exp_q.pop_front());
                    check({nm, "_latency"}, 64'(cyc - acc), 64'd57);
`ifdef FPDIV_EXCEPT_FLAGS_EN
                    check({nm, "_flags"}, 64'(except_flags), 64'(f));
`endif
                end
                seen = 1'b1;
                held = final_quotient;
            end else begin
                check("hold_value", final_quotient, held);
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_ready) seen = 1'b0;
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                        input logic [4:0] f, input string nm);
        int guard = 0;
        @(posedge clk);
        #1;
        while (!in_ready && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check({nm, "_accept_timeout"}, 64'(in_ready), 64'd1);
            return;
        end
        A = a;
        B = b;
        in_valid = 1'b1;
        exp_q.push_back(e);
        flg_q.push_back(f);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0 || out_valid)
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_quotient", final_quotient, 64'h0);
        rst_n = 1'b1;

        send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'b00000, "six_div_two");
        send(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FD5_5555_5555_5555, 5'b00001, "one_third");
        send(64'h4014_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FFA_AAAA_AAAA_AAAB, 5'b00001, "five_thirds_rnd_up");
        send(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FE5_5555_5555_5555, 5'b00001, "two_thirds");
        send(64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 5'b01000, "neg_div_zero");
        send(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b10000, "zero_div_zero");
        send(64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 5'b00101, "overflow");
        send(64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000, 5'b00011, "underflow");
        send(64'h8010_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'b00011, "neg_underflow");
        send(64'hBFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hBFE0_0000_0000_0000, 5'b00000, "neg_half");
        send(64'h7FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 5'b00000, "inf_div_two");
        send(64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 5'b00000, "two_div_neg_inf");
        send(64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b10000, "inf_div_inf");
        send(64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b00000, "qnan_in");
        send(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 5'b10000, "snan_in");
        send(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'b00000, "one_div_one");
        drain();

        // Back-pressure, then a waiting operand pair taken one cycle after the consume.
        out_ready = 1'b0;
        send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'b00000, "held_result");
        g = 0;
        while (!out_valid && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("held_arrives", 64'(out_valid), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        A = 64'h4024_0000_0000_0000;
        B = 64'h4010_0000_0000_0000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consume_out_valid", 64'(out_valid), 64'd0);
        check("consume_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(64'h4004_0000_0000_0000);
        flg_q.push_back(5'b00000);
        nm_q.push_back("ten_div_four");
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        check("accept_after_consume", 64'(in_ready), 64'd0);
        drain();

        // Reset in the middle of a division drops it.
        send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'b00000, "aborted");
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_quotient", final_quotient, 64'h0);
        void'(exp_q.pop_back());
        void'(flg_q.pop_back());
        void'(nm_q.pop_back());
        void'(acc_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'b00000, "after_reset");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
